// File: rtl/zeroriscy_mem_arb_pkg.sv
// zeroriscy_mem_arb_pkg: shared types for the
// instruction/data memory port arbiter.
package zeroriscy_mem_arb_pkg;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/zeroriscy_mem_arbiter_if.sv
// zeroriscy_mem_arbiter_if: req/gnt/rvalid memory bus.
// master issues requests, slave grants and responds.
interface zeroriscy_mem_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/zeroriscy_id_fifo.sv
// zeroriscy_id_fifo: in-order requester-ID queue that
// steers each memory response back to its issuer.
module zeroriscy_id_fifo
  import zeroriscy_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  req_id_e       push_id,
  input  logic          pop,
  output req_id_e       head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wptr_q] = push_id;
      wptr_d        = bump(wptr_q);
    end
    if (pop) begin
      rptr_d = bump(rptr_q);
    end
  end

  // State registers, emptied by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head  = req_id_e'(mem_q[rptr_q]);
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/zeroriscy_mem_arbiter.sv
// zeroriscy_mem_arbiter: shares one memory port between
// fetch (m0) and data (m1), data first, fetch unstarved.
module zeroriscy_mem_arbiter
  import zeroriscy_mem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  zeroriscy_mem_arbiter_if.slave  m0,
  zeroriscy_mem_arbiter_if.slave  m1,
  zeroriscy_mem_arbiter_if.master s,
  output logic                    orphan_rsp
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          orphan_q, orphan_d;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          issue_ok, starved, fwd, accept;
  logic          g0, g1, rsp_ok, rv0, rv1;
  req_id_e       win, head;
  mem_req_t      m0_pl, m1_pl, fwd_pl;

  assign m0_pl = '{we: m0.we, be: m0.be,
                   addr: m0.addr, wdata: m0.wdata};
  assign m1_pl = '{we: m1.we, be: m1.be,
                   addr: m1.addr, wdata: m1.wdata};

  assign issue_ok = (count < CW'(MAX_OUTSTANDING));
  assign starved  = (starve_q == SW'(STARVE_LIMIT));
  assign fwd      = ~rst & issue_ok & (m0.req | m1.req);
  assign accept   = fwd & s.gnt;

  // Data wins contention unless fetch has waited too long
  always_comb begin
    win = REQ_INSTR;
    if (m1.req && !(m0.req && starved)) begin
      win = REQ_DATA;
    end
  end

  // Forward the winner's payload, zero when nothing issues
  always_comb begin
    fwd_pl = '0;
    if (fwd) begin
      fwd_pl = (win == REQ_DATA) ? m1_pl : m0_pl;
    end
  end

  assign s.req   = fwd;
  assign s.we    = fwd_pl.we;
  assign s.be    = fwd_pl.be;
  assign s.addr  = fwd_pl.addr;
  assign s.wdata = fwd_pl.wdata;

  assign g0     = accept & (win == REQ_INSTR);
  assign g1     = accept & (win == REQ_DATA);
  assign m0.gnt = g0;
  assign m1.gnt = g1;

  // A response with nothing outstanding is never routed
  assign rsp_ok    = ~rst & s.rvalid & ~empty;
  assign rv0       = rsp_ok & (head == REQ_INSTR);
  assign rv1       = rsp_ok & (head == REQ_DATA);
  assign m0.rvalid = rv0;
  assign m1.rvalid = rv1;
  assign m0.rdata  = rv0 ? s.rdata : '0;
  assign m1.rdata  = rv1 ? s.rdata : '0;
  assign m0.err    = rv0 & s.err;
  assign m1.err    = rv1 & s.err;

  zeroriscy_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept & ~full),
    .push_id (win),
    .pop     (s.rvalid & ~empty),
    .head    (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  // Count fetch wait cycles; note stray responses
  always_comb begin
    starve_d = starve_q;
    if (!m0.req || g0) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + SW'(1);
    end
    orphan_d = orphan_q | (s.rvalid & empty);
  end

  // Arbitration state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      orphan_q <= orphan_d;
    end
  end

  assign orphan_rsp = orphan_q;

endmodule

// File: tb/tb_zeroriscy_mem_arbiter.sv
// tb_zeroriscy_mem_arbiter: directed and random traffic
// checked against a queue-based reference model.
module tb_zeroriscy_mem_arbiter;
  import zeroriscy_mem_arb_pkg::*;

  localparam int MAXO = 2;
  localparam int LIM  = 4;

  logic clk = 1'b0;
  logic rst;
  logic orphan_rsp;

  zeroriscy_mem_arbiter_if m0_if ();
  zeroriscy_mem_arbiter_if m1_if ();
  zeroriscy_mem_arbiter_if s_if ();

  zeroriscy_mem_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .STARVE_LIMIT    (LIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .s          (s_if),
    .orphan_rsp (orphan_rsp)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: outstanding IDs, fetch wait, stray flag
  int ids[$];
  int starve = 0;
  bit orphan_m = 0;

  // requester / memory stimulus knobs
  bit act0 = 0, act1 = 0;
  mem_req_t pay0, pay1;
  int p_req = 0;
  bit gnt_rand = 0, rv_rand = 0, err_rand = 0;
  bit err_fix = 0, rv_force = 0, rd_fix_en = 0;
  logic [31:0] rd_fix = '0;
  int rv_hold = 0;
  bit log_en = 0, bp_en = 0;
  int bp_stall = 0;
  bit glog[$];

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic mem_req_t rnd_pay();
    mem_req_t p;
    p.we    = 1'($urandom);
    p.be    = 4'($urandom);
    p.addr  = $urandom;
    p.wdata = $urandom;
    return p;
  endfunction

  task automatic rst_chk(string tag);
    chk({tag, "_s"}, 128'({s_if.req, s_if.we, s_if.be,
        s_if.addr, s_if.wdata}), '0);
    chk({tag, "_m"}, 128'({m0_if.gnt, m0_if.rvalid,
        m0_if.rdata, m0_if.err, m1_if.gnt, m1_if.rvalid,
        m1_if.rdata, m1_if.err, orphan_rsp}), '0);
  endtask

  task automatic cycle();
    mem_req_t d, ep;
    bit g, rv, esr, w0, eg0, eg1, erv0, erv1, er;
    logic [31:0] rd;
    if (!act0 && $urandom_range(0, 99) < p_req) begin
      act0 = 1; pay0 = rnd_pay();
    end
    if (!act1 && $urandom_range(0, 99) < p_req) begin
      act1 = 1; pay1 = rnd_pay();
    end
    d = act0 ? pay0 : rnd_pay();
    m0_if.req = act0; m0_if.we = d.we; m0_if.be = d.be;
    m0_if.addr = d.addr; m0_if.wdata = d.wdata;
    d = act1 ? pay1 : rnd_pay();
    m1_if.req = act1; m1_if.we = d.we; m1_if.be = d.be;
    m1_if.addr = d.addr; m1_if.wdata = d.wdata;
    g  = gnt_rand ? 1'($urandom) : 1'b1;
    rv = rv_force || (ids.size() > 0 && rv_hold == 0
         && (!rv_rand || 1'($urandom)));
    rd = rd_fix_en ? rd_fix : $urandom;
    er = err_rand ? 1'($urandom) : err_fix;
    s_if.gnt = g; s_if.rvalid = rv;
    s_if.rdata = rd; s_if.err = er;
    @(negedge clk);
    esr = (ids.size() < MAXO) && (act0 || act1);
    w0  = act0 && (!act1 || starve == LIM);
    ep  = '0;
    if (esr) ep = w0 ? pay0 : pay1;
    eg0 = esr && g && w0;
    eg1 = esr && g && !w0;
    erv0 = rv && ids.size() > 0 && ids[0] == 0;
    erv1 = rv && ids.size() > 0 && ids[0] == 1;
    chk("s_req", 128'(s_if.req), 128'(esr));
    chk("s_pay", 128'({s_if.we, s_if.be, s_if.addr,
        s_if.wdata}), 128'(ep));
    chk("gnt", 128'({m0_if.gnt, m1_if.gnt}),
        128'({eg0, eg1}));
    chk("rvalid", 128'({m0_if.rvalid, m1_if.rvalid}),
        128'({erv0, erv1}));
    chk("m0_rsp", 128'({m0_if.rdata, m0_if.err}),
        erv0 ? 128'({rd, er}) : '0);
    chk("m1_rsp", 128'({m1_if.rdata, m1_if.err}),
        erv1 ? 128'({rd, er}) : '0);
    chk("orphan", 128'(orphan_rsp), 128'(orphan_m));
    if (log_en && (m0_if.gnt || m1_if.gnt))
      glog.push_back(m1_if.gnt);
    if (bp_en && !s_if.req) bp_stall++;
    if (rv) begin
      if (ids.size() > 0) void'(ids.pop_front());
      else orphan_m = 1;
    end
    if (esr && g) ids.push_back(w0 ? 0 : 1);
    if (!act0 || eg0) starve = 0;
    else if (starve < LIM) starve++;
    if (eg0) act0 = 0;
    if (eg1) act1 = 0;
    if (rv_hold > 0) rv_hold--;
    rv_force = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_read();
    act0 = 1;
    pay0 = '{we: 1'b0, be: 4'hF,
             addr: 32'h8010_0000, wdata: '0};
    rd_fix_en = 1; rd_fix = 32'hDEAD_BEEF;
    repeat (3) cycle();
    rd_fix_en = 0;
  endtask

  task automatic drive_idle();
    m0_if.req = 0; m0_if.we = 0; m0_if.be = 0;
    m0_if.addr = 0; m0_if.wdata = 0;
    m1_if.req = 0; m1_if.we = 0; m1_if.be = 0;
    m1_if.addr = 0; m1_if.wdata = 0;
    s_if.gnt = 0; s_if.rvalid = 0;
    s_if.rdata = 0; s_if.err = 0;
  endtask

  initial begin
    logic [9:0] seq;
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    m0_if.req = 1; m1_if.req = 1;
    s_if.gnt = 1; s_if.rvalid = 1; s_if.rdata = '1;
    #1;
    rst_chk("reset");
    drive_idle();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    fetch_read();

    log_en = 1; p_req = 100;
    repeat (12) cycle();
    log_en = 0; p_req = 0;
    repeat (6) cycle();
    for (int i = 0; i < 10; i++)
      seq[9-i] = (i < glog.size()) ? glog[i] : 1'bx;
    chk("gnt_seq", 128'(seq), 128'(10'b1111011110));

    act0 = 1; act1 = 1;
    pay0 = rnd_pay(); pay1 = rnd_pay();
    p_req = 100; rv_hold = 7; bp_en = 1;
    repeat (9) cycle();
    bp_en = 0; p_req = 0;
    chk("bp_stall", 128'(bp_stall), 128'(6));
    repeat (8) cycle();

    act1 = 1;
    pay1 = '{we: 1'b1, be: 4'b0011,
             addr: 32'h0000_1000, wdata: 32'h1234_5678};
    err_fix = 1;
    repeat (2) cycle();
    err_fix = 0;
    cycle();

    rv_force = 1;
    repeat (3) cycle();
    chk("orphan_set", 128'(orphan_rsp), 128'(1));

    act0 = 1; act1 = 1; rv_hold = 20;
    repeat (2) cycle();
    #2;
    rst = 1'b1;
    m0_if.req = 1; m1_if.req = 1;
    s_if.gnt = 1; s_if.rvalid = 1;
    #1;
    rst_chk("midrst");
    ids.delete(); starve = 0; orphan_m = 0;
    act0 = 0; act1 = 0; rv_hold = 0;
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    fetch_read();

    p_req = 40; gnt_rand = 1; rv_rand = 1; err_rand = 1;
    repeat (2000) cycle();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zeroriscy_mem_arbiter.md
Name: zeroriscy_mem_arbiter

Overview:
- Shares one req/gnt/rvalid memory port between the zero-riscy instruction-fetch requester (m0) and the data requester (m1).
- Sits between the core and a single memory port of the test-bench SRAM, so instruction and data traffic can target one port.
- Arbitrates each cycle: data has fixed priority, with a starvation limit that protects instruction fetch.
- Tracks outstanding transactions in an ID FIFO and routes each response back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2, depth of the response-routing ID FIFO (1..8); limits accepted-but-unanswered transactions.
- STARVE_LIMIT, 4, consecutive cycles m0 may be requesting without a grant before m0 is forced to win (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  instruction requester, request
- m0_we  in  1  instruction requester, write enable
- m0_be  in  4  instruction requester, byte enables
- m0_addr  in  32  instruction requester, byte address
- m0_wdata  in  32  instruction requester, write data
- m0_gnt  out  1  instruction requester, grant
- m0_rvalid  out  1  instruction requester, response valid
- m0_rdata  out  32  instruction requester, read data
- m0_err  out  1  instruction requester, response error
- m1_*  same set and widths as m0_*  data requester
- s_req  out  1  memory request
- s_we  out  1  memory write enable
- s_be  out  4  memory byte enables
- s_addr  out  32  memory byte address
- s_wdata  out  32  memory write data
- s_gnt  in  1  memory grant
- s_rvalid  in  1  memory response valid
- s_rdata  in  32  memory read data
- s_err  in  1  memory response error
- orphan_rsp  out  1  sticky flag: s_rvalid arrived with no outstanding transaction

Behaviour:
- Reset (async, active-high):
  - ID FIFO empty; count=0; starvation counter=0; orphan_rsp=0.
  - All outputs 0 while rst is high.
- Issue enable: issue_ok = (count < MAX_OUTSTANDING). Back-pressure is based only on count; a same-cycle pop does not free a slot.
- Winner selection (combinational):
  - If only one requester has req high, it wins.
  - If both are high, m1 wins, unless starve_cnt == STARVE_LIMIT, in which case m0 wins.
- Request forwarding: s_req = issue_ok & (m0_req | m1_req). s_we, s_be, s_addr and s_wdata mux from the winner. When s_req=0 these outputs are driven 0.
- Grant: mX_gnt = s_gnt & s_req & (winner==X). The loser's gnt is 0. Grant is in the same cycle, combinational from s_gnt.
- Accept: accept = s_req & s_gnt. On accept, push the winner ID (0/1) into the FIFO at the next clk edge.
- Starvation counter:
  - Increments when m0_req=1 and m0 is not granted, saturating at STARVE_LIMIT.
  - Clears when m0 is granted or m0_req=0.
- Response routing:
  - s_rvalid pops the FIFO head.
  - mID_rvalid = s_rvalid; the other requester's rvalid = 0.
  - s_rdata and s_err are broadcast to both rdata/err outputs but qualified only by the routed rvalid.
  - Zero added latency: combinational from s_rvalid and the FIFO head.
- Simultaneous push and pop: legal when count < MAX_OUTSTANDING; count is unchanged; ordering is preserved (in-order memory).
- Orphan response: s_rvalid with count==0 drives no mX_rvalid, does not pop, and sets orphan_rsp (cleared only by rst).
- Requester holding: a requester keeps req and payload stable until gnt. The block does not latch payload.
- Reset mid-operation: in-flight IDs are discarded. A later s_rvalid then raises orphan_rsp; the bench must not issue after reset until the memory has drained.
- Count width: $clog2(MAX_OUTSTANDING+1). FIFO pointers are $clog2(MAX_OUTSTANDING) bits with explicit wrap at MAX_OUTSTANDING-1 (handles non-power-of-2 depths).

Decomposition:
- Package zeroriscy_mem_arb_pkg: typedef req_id_e {REQ_INSTR=1'b0, REQ_DATA=1'b1}; typedef mem_req_t {we, be[3:0], addr[31:0], wdata[31:0]}.
- One sub-module: zeroriscy_id_fifo (parameterised depth, 1-bit payload, push/pop/count/empty/full).
- Arbitration, starvation counter and muxing stay in the top.

Test Plan:
- Single instruction read: m0_req=1 addr=0x80100000, memory with s_gnt=1 and 1-cycle latency, s_rdata=0xDEADBEEF -> m0_gnt same cycle, m0_rvalid next cycle with rdata=0xDEADBEEF, m1_rvalid=0.
- Contention: m0_req=m1_req=1 continuously, STARVE_LIMIT=4 -> grant sequence m1,m1,m1,m1,m0,m1,m1,m1,m1,m0…; each rvalid routed to the matching requester.
- Back-pressure: MAX_OUTSTANDING=2, memory holds s_rvalid low for 5 cycles after two accepts -> s_req=0 and both gnt=0 until the first s_rvalid; the next issue occurs the cycle after that pop.
- Write path: m1 write be=4'b0011 wdata=0x12345678 -> s_we=1, s_be=0011, s_wdata passed through; m1_rvalid one cycle later; s_err=1 injected -> m1_err=1, m0_err ignored.
- Orphan response: s_rvalid pulse with no outstanding transaction -> no mX_rvalid; orphan_rsp=1 and held until rst.
- Async reset mid-flight: assert rst between a clock edge and the next, with 2 outstanding -> outputs 0 immediately, count=0; after release, a new m0 read completes normally.
